// File: rtl/uart_mmio_ctrl_if.sv
// CPU-side MMIO strobes plus the transmitter/receiver byte handshakes of the UART controller.
// The controller attaches through slave; the CPU/UART side (or a bench) drives master.
interface uart_mmio_ctrl_if;
  logic [7:0]  io_addr;
  logic        io_we;
  logic        io_re;
  logic [7:0]  io_wdata;
  logic [31:0] io_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        rx_overrun;

  modport slave (
    input  io_addr, io_we, io_re, io_wdata, tx_ready, rx_data, rx_valid,
    output io_rdata, tx_data, tx_valid, rx_ready, rx_overrun
  );

  modport master (
    output io_addr, io_we, io_re, io_wdata, tx_ready, rx_data, rx_valid,
    input  io_rdata, tx_data, tx_valid, rx_ready, rx_overrun
  );
endinterface

// File: rtl/uart_mmio_ctrl.sv
// MMIO front end for the UART: TX FIFO fed by CPU stores and drained to the transmitter,
// RX FIFO filled by the receiver and popped by CPU loads, with a sticky overrun flag.
module uart_mmio_ctrl #(
  parameter int DEPTH = 8
) (
  input logic             clk,
  input logic             rst,
  uart_mmio_ctrl_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [7:0] ADDR_STATUS = 8'h00;
  localparam logic [7:0] ADDR_RX     = 8'h04;
  localparam logic [7:0] ADDR_TX     = 8'h08;
  localparam logic [7:0] ADDR_CLEAR  = 8'h0C;

  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [7:0]       tx_mem [DEPTH];
  logic [7:0]       rx_mem [DEPTH];
  logic [PTR_W-1:0] tx_wr_ptr, tx_rd_ptr, rx_wr_ptr, rx_rd_ptr;
  logic [PTR_W:0]   tx_count, rx_count;
  logic [31:0]      rdata_q;
  logic             overrun_q;

  logic        tx_full, tx_empty, rx_full, rx_empty;
  logic        tx_push, tx_pop, rx_push, rx_pop;
  logic        clear_wr, overrun_set;
  logic [31:0] status;
  logic [31:0] rd_mux;

  assign tx_full  = (tx_count == CNT_FULL);
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == CNT_FULL);
  assign rx_empty = (rx_count == '0);

  // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
  assign tx_pop      = !tx_empty && bus.tx_ready;
  assign tx_push     = bus.io_we && (bus.io_addr == ADDR_TX) && (!tx_full || tx_pop);
  assign rx_pop      = bus.io_re && (bus.io_addr == ADDR_RX) && !rx_empty;
  assign rx_push     = bus.rx_valid && (!rx_full || rx_pop);
  assign overrun_set = bus.rx_valid && rx_full && !rx_pop;
  assign clear_wr    = bus.io_we && (bus.io_addr == ADDR_CLEAR);

  always_comb begin
    status        = '0;
    status[0]     = !tx_full;
    status[1]     = !rx_empty;
    status[2]     = overrun_q;
    status[11:8]  = 4'(rx_count);
    status[15:12] = 4'(tx_count);
  end

  always_comb begin
    rd_mux = '0;
    case (bus.io_addr)
      ADDR_STATUS: rd_mux = status;
      ADDR_RX:     rd_mux = rx_empty ? 32'h0 : {24'h0, rx_mem[rx_rd_ptr]};
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
      overrun_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + PTR_ONE;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PTR_ONE;
      if (tx_push && !tx_pop)      tx_count <= tx_count + CNT_ONE;
      else if (!tx_push && tx_pop) tx_count <= tx_count - CNT_ONE;

      if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
      if (rx_push && !rx_pop)      rx_count <= rx_count + CNT_ONE;
      else if (!rx_push && rx_pop) rx_count <= rx_count - CNT_ONE;

      // A fresh overrun beats a simultaneous CLEAR so no drop goes unreported.
      if (overrun_set)   overrun_q <= 1'b1;
      else if (clear_wr) overrun_q <= 1'b0;

      if (bus.io_re) rdata_q <= rd_mux;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= bus.io_wdata;
    if (rx_push) rx_mem[rx_wr_ptr] <= bus.rx_data;
  end

  assign bus.tx_valid   = !tx_empty;
  assign bus.tx_data    = tx_mem[tx_rd_ptr];
  assign bus.rx_ready   = 1'b1;
  assign bus.rx_overrun = overrun_q;
  assign bus.io_rdata   = rdata_q;
endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Self-checking bench for uart_mmio_ctrl: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_uart_mmio_ctrl;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  uart_mmio_ctrl_if bus();

  uart_mmio_ctrl #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference model: two byte queues, the sticky flag and the last load result.
  byte unsigned m_tx[$];
  byte unsigned m_rx[$];
  bit           m_ovr = 1'b0;
  logic [31:0]  m_rdata = '0;
  byte unsigned tx_seen[$];

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s        = '0;
    s[0]     = (m_tx.size() < DEPTH);
    s[1]     = (m_rx.size() != 0);
    s[2]     = m_ovr;
    s[11:8]  = 4'(m_rx.size());
    s[15:12] = 4'(m_tx.size());
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Model update: loads see state before this cycle's pushes/pops; CLEAR applies before a new overrun.
  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_tx.delete();
      m_rx.delete();
      m_ovr   = 1'b0;
      m_rdata = '0;
    end else begin
      logic [31:0] st;
      bit tx_pop, rx_pop;
      st     = model_status();
      tx_pop = (m_tx.size() != 0) && bus.tx_ready;
      rx_pop = bus.io_re && (bus.io_addr == 8'h04) && (m_rx.size() != 0);
      if (bus.io_re) begin
        if (bus.io_addr == 8'h00)                            m_rdata = st;
        else if (bus.io_addr == 8'h04 && m_rx.size() != 0)   m_rdata = {24'h0, m_rx[0]};
        else                                                 m_rdata = '0;
      end
      if (tx_pop) void'(m_tx.pop_front());
      if (bus.io_we && bus.io_addr == 8'h08 && m_tx.size() < DEPTH) m_tx.push_back(bus.io_wdata);
      if (rx_pop) void'(m_rx.pop_front());
      if (bus.io_we && bus.io_addr == 8'h0C) m_ovr = 1'b0;
      if (bus.rx_valid) begin
        if (m_rx.size() < DEPTH) m_rx.push_back(bus.rx_data);
        else                     m_ovr = 1'b1;
      end
    end
  end

  // Record every byte handed to the transmitter, sampled before the edge takes effect.
  initial forever begin
    @(posedge clk);
    if (rst && bus.tx_valid && bus.tx_ready) tx_seen.push_back(bus.tx_data);
  end

  // Per-cycle comparison of all outputs against the model.
  initial forever begin
    @(negedge clk);
    checkOutput("tx_valid", 32'(bus.tx_valid), 32'(m_tx.size() != 0));
    if (m_tx.size() != 0) checkOutput("tx_data", 32'(bus.tx_data), 32'(m_tx[0]));
    checkOutput("io_rdata", bus.io_rdata, m_rdata);
    checkOutput("rx_overrun", 32'(bus.rx_overrun), 32'(m_ovr));
    checkOutput("rx_ready", 32'(bus.rx_ready), 32'(1));
  end

  // One cycle of CPU/receiver stimulus, applied at a falling edge and held until the next one.
  task automatic applyStimulus(input logic we, input logic re, input logic [7:0] addr,
                               input logic [7:0] wdata, input logic rxv, input logic [7:0] rxd);
    bus.io_we    = we;
    bus.io_re    = re;
    bus.io_addr  = addr;
    bus.io_wdata = wdata;
    bus.rx_valid = rxv;
    bus.rx_data  = rxd;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic cpuWrite(input logic [7:0] addr, input logic [7:0] data);
    applyStimulus(1'b1, 1'b0, addr, data, 1'b0, 8'h00);
  endtask

  task automatic cpuRead(input logic [7:0] addr, output logic [31:0] data);
    applyStimulus(1'b0, 1'b1, addr, 8'h00, 1'b0, 8'h00);
    data = bus.io_rdata;
  endtask

  task automatic rxByte(input logic [7:0] b);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, b);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  addrs [6];
    addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h04};

    bus.io_we = 1'b0; bus.io_re = 1'b0; bus.io_addr = '0; bus.io_wdata = '0;
    bus.rx_valid = 1'b0; bus.rx_data = '0; bus.tx_ready = 1'b0;

    // Reset state
    repeat (5) @(negedge clk);
    checkOutput("reset io_rdata", bus.io_rdata, 32'h0);
    checkOutput("reset tx_valid", 32'(bus.tx_valid), 32'h0);
    checkOutput("reset rx_overrun", 32'(bus.rx_overrun), 32'h0);
    rst = 1'b1;
    idle(1);
    cpuRead(8'h00, d);
    checkOutput("reset status", d, 32'h0000_0001);

    // TX ordering
    bus.tx_ready = 1'b0;
    cpuWrite(8'h08, 8'h0D); cpuWrite(8'h08, 8'h0A);
    cpuWrite(8'h08, 8'h31); cpuWrite(8'h08, 8'h35);
    cpuRead(8'h00, d);
    checkOutput("tx4 status", d, 32'h0000_4001);
    tx_seen.delete();
    bus.tx_ready = 1'b1;
    idle(8);
    checkOutput("tx order count", 32'(tx_seen.size()), 32'd4);
    if (tx_seen.size() == 4) begin
      checkOutput("tx order 0", 32'(tx_seen[0]), 32'h0D);
      checkOutput("tx order 1", 32'(tx_seen[1]), 32'h0A);
      checkOutput("tx order 2", 32'(tx_seen[2]), 32'h31);
      checkOutput("tx order 3", 32'(tx_seen[3]), 32'h35);
    end
    checkOutput("tx drained valid", 32'(bus.tx_valid), 32'h0);

    // TX full: ninth write dropped
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) cpuWrite(8'h08, 8'(8'h61 + i));
    cpuRead(8'h00, d);
    checkOutput("tx full status", d, 32'h0000_8000);
    cpuWrite(8'h08, 8'h69);
    cpuRead(8'h00, d);
    checkOutput("tx full drop status", d, 32'h0000_8000);
    tx_seen.delete();
    bus.tx_ready = 1'b1;
    idle(12);
    checkOutput("tx full count", 32'(tx_seen.size()), 32'd8);
    for (int i = 0; i < 8 && i < tx_seen.size(); i++)
      checkOutput("tx full byte", 32'(tx_seen[i]), 32'(8'h61 + i));
    bus.tx_ready = 1'b0;

    // RX overrun
    for (int i = 0; i < 9; i++) rxByte(8'(8'h73 + i));
    idle(1);
    checkOutput("rx overrun flag", 32'(bus.rx_overrun), 32'h1);
    cpuRead(8'h00, d);
    checkOutput("rx overrun status", d, 32'h0000_0807);
    for (int i = 0; i < 8; i++) begin
      cpuRead(8'h04, d);
      checkOutput("rx pop byte", d, 32'(8'h73 + i));
    end
    cpuRead(8'h04, d);
    checkOutput("rx empty read", d, 32'h0);
    cpuWrite(8'h0C, 8'h00);
    idle(1);
    checkOutput("rx overrun cleared", 32'(bus.rx_overrun), 32'h0);

    // Simultaneous push and pop with RX full
    for (int i = 0; i < 8; i++) rxByte(8'(8'h10 + i));
    applyStimulus(1'b0, 1'b1, 8'h04, 8'h00, 1'b1, 8'hCA);
    checkOutput("rx simul head", bus.io_rdata, 32'h10);
    cpuRead(8'h00, d);
    checkOutput("rx simul status", d, 32'h0000_0803);
    for (int i = 0; i < 8; i++) begin
      cpuRead(8'h04, d);
      checkOutput("rx simul drain", d, (i == 7) ? 32'hCA : 32'(8'h11 + i));
    end

    // Simultaneous push and pop with TX full
    for (int i = 0; i < 8; i++) cpuWrite(8'h08, 8'(8'h80 + i));
    tx_seen.delete();
    bus.tx_ready = 1'b1;
    cpuWrite(8'h08, 8'h99);
    bus.tx_ready = 1'b0;
    cpuRead(8'h00, d);
    checkOutput("tx simul status", d, 32'h0000_8000);
    bus.tx_ready = 1'b1;
    idle(12);
    checkOutput("tx simul count", 32'(tx_seen.size()), 32'd9);
    if (tx_seen.size() == 9) checkOutput("tx simul last", 32'(tx_seen[8]), 32'h99);
    bus.tx_ready = 1'b0;

    // Reset mid-operation
    for (int i = 0; i < 3; i++) cpuWrite(8'h08, 8'(8'hA0 + i));
    rxByte(8'h55); rxByte(8'h56);
    cpuRead(8'h00, d);
    checkOutput("pre-reset status", d, 32'h0000_3203);
    #2 rst = 1'b0;
    #1;
    checkOutput("async reset tx_valid", 32'(bus.tx_valid), 32'h0);
    checkOutput("async reset io_rdata", bus.io_rdata, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle(1);
    cpuRead(8'h00, d);
    checkOutput("post-reset status", d, 32'h0000_0001);

    // Randomized traffic, checked every cycle by the model
    for (int n = 0; n < 2000; n++) begin
      bus.tx_ready = ($urandom_range(0, 2) != 0);
      applyStimulus(($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                    addrs[$urandom_range(0, 5)], 8'($urandom),
                    ($urandom_range(0, 1) == 0), 8'($urandom));
    end
    bus.tx_ready = 1'b1;
    idle(DEPTH + 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
